// File: rtl/axi_ofdmbbp_rx_cmd_sched_if.sv
// Register-bus and command-stream signals of the RX command scheduler.
// cmd_*: the slave holds cmd_valid/cmd_data stable until the cycle where cmd_valid && cmd_ready.
interface axi_ofdmbbp_rx_cmd_sched_if;
   logic        up_wreq;
   logic [13:0] up_waddr;
   logic [31:0] up_wdata;
   logic        up_wack;
   logic        up_rreq;
   logic [13:0] up_raddr;
   logic [31:0] up_rdata;
   logic        up_rack;
   logic        cmd_valid;
   logic [31:0] cmd_data;
   logic        cmd_ready;
   logic        sched_done;

   modport slave (
      input  up_wreq, up_waddr, up_wdata, up_rreq, up_raddr, cmd_ready,
      output up_wack, up_rdata, up_rack, cmd_valid, cmd_data, sched_done
   );

   modport master (
      output up_wreq, up_waddr, up_wdata, up_rreq, up_raddr, cmd_ready,
      input  up_wack, up_rdata, up_rack, cmd_valid, cmd_data, sched_done
   );
endinterface

// File: rtl/axi_ofdmbbp_rx_cmd_sched.sv
// RX command scheduler: a register-programmed table of commands issued (optionally repeated)
// into the RX command FIFO, with a one-deep CPU direct command that takes priority.
module axi_ofdmbbp_rx_cmd_sched #(
   parameter int unsigned TABLE_AW  = 4,
   parameter logic [13:0] BASE_ADDR = 14'h0300
) (
   input logic                        up_clk,
   input logic                        up_rstn,
   axi_ofdmbbp_rx_cmd_sched_if.slave  bus
);
   localparam int unsigned           DEPTH    = 1 << TABLE_AW;
   localparam logic [7:0]            TBL_BASE = 8'h80;
   localparam logic [TABLE_AW-1:0]   IDX_ONE  = 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_ABORT, S_DONE} state_e;

   state_e              state_q;
   logic [TABLE_AW-1:0] cur_idx_q, cur_idx_d;
   logic [7:0]          cur_rep_q, cur_rep_d;
   logic                fetch_end_q, fetch_last_d;
   logic                loop_q;
   logic [TABLE_AW-1:0] last_idx_q;
   logic [7:0]          repeat_q;
   logic                done_q, ovf_q, sched_done_q;
   logic                dir_valid_q;
   logic [31:0]         dir_data_q;
   logic                out_valid_q, out_tbl_q, out_last_q;
   logic [31:0]         out_data_q;
   logic [31:0]         issued_q;
   logic [31:0]         table_q [DEPTH];
   logic                wack_q, rack_q;
   logic [31:0]         rdata_q;

   logic       wr_win, rd_win, wr_ctrl, wr_cfg, wr_dir, wr_tbl, rd_tbl, rd_status;
   logic       start_wr, abort_wr;
   logic [7:0] wr_off, rd_off;
   logic       handshake, out_free, tbl_hs, last_hs, load_dir, fetch_tbl, busy;
   logic [31:0] cfg_w, status_w, rd_mux;

   assign wr_off    = bus.up_waddr[7:0];
   assign rd_off    = bus.up_raddr[7:0];
   assign wr_win    = bus.up_wreq && (bus.up_waddr[13:8] == BASE_ADDR[13:8]);
   assign rd_win    = bus.up_rreq && (bus.up_raddr[13:8] == BASE_ADDR[13:8]);
   assign wr_ctrl   = wr_win && (wr_off == 8'h00);
   assign wr_cfg    = wr_win && (wr_off == 8'h01);
   assign wr_dir    = wr_win && (wr_off == 8'h03);
   assign wr_tbl    = wr_win && ((wr_off >> TABLE_AW) == (TBL_BASE >> TABLE_AW));
   assign rd_tbl    = (rd_off >> TABLE_AW) == (TBL_BASE >> TABLE_AW);
   assign rd_status = rd_win && (rd_off == 8'h02);
   assign start_wr  = wr_ctrl && bus.up_wdata[0];
   assign abort_wr  = wr_ctrl && bus.up_wdata[1];

   assign handshake = out_valid_q && bus.cmd_ready;
   assign out_free  = !out_valid_q || bus.cmd_ready;
   assign tbl_hs    = handshake && out_tbl_q;
   assign last_hs   = tbl_hs && out_last_q;
   assign load_dir  = out_free && dir_valid_q;
   // An abort arriving this cycle must not pull in a fresh table entry behind it.
   assign fetch_tbl = out_free && !dir_valid_q && (state_q == S_RUN) && !fetch_end_q && !abort_wr;
   assign busy      = (state_q != S_IDLE);

   // Position of the entry after the one being fetched now; last_idx is compared live.
   always_comb begin
      cur_idx_d    = cur_idx_q;
      cur_rep_d    = cur_rep_q;
      fetch_last_d = 1'b0;
      if (cur_idx_q != last_idx_q) begin
         cur_idx_d = cur_idx_q + IDX_ONE;
      end else if (loop_q || (cur_rep_q != repeat_q)) begin
         cur_idx_d = '0;
         if (!loop_q) cur_rep_d = cur_rep_q + 8'd1;
      end else begin
         fetch_last_d = 1'b1;
      end
   end

   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
         state_q      <= S_IDLE;
         cur_idx_q    <= '0;
         cur_rep_q    <= '0;
         fetch_end_q  <= 1'b0;
         done_q       <= 1'b0;
         ovf_q        <= 1'b0;
         sched_done_q <= 1'b0;
         dir_valid_q  <= 1'b0;
         dir_data_q   <= '0;
         out_valid_q  <= 1'b0;
         out_tbl_q    <= 1'b0;
         out_last_q   <= 1'b0;
         out_data_q   <= '0;
         issued_q     <= '0;
      end else begin
         sched_done_q <= 1'b0;
         if (rd_status) begin
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
         end
         if (wr_dir && dir_valid_q) ovf_q <= 1'b1;
         if (load_dir) dir_valid_q <= 1'b0;
         if (wr_dir && !dir_valid_q) begin
            dir_valid_q <= 1'b1;
            dir_data_q  <= bus.up_wdata;
         end

         if (handshake) begin
            out_valid_q <= 1'b0;
            issued_q    <= issued_q + 32'd1;
         end
         if (load_dir) begin
            out_valid_q <= 1'b1;
            out_data_q  <= dir_data_q;
            out_tbl_q   <= 1'b0;
            out_last_q  <= 1'b0;
         end else if (fetch_tbl) begin
            out_valid_q <= 1'b1;
            out_data_q  <= table_q[cur_idx_q];
            out_tbl_q   <= 1'b1;
            out_last_q  <= fetch_last_d;
            cur_idx_q   <= cur_idx_d;
            cur_rep_q   <= cur_rep_d;
            fetch_end_q <= fetch_last_d;
         end

         case (state_q)
            S_IDLE: begin
               if (start_wr && !abort_wr) begin
                  state_q     <= S_RUN;
                  cur_idx_q   <= '0;
                  cur_rep_q   <= '0;
                  fetch_end_q <= 1'b0;
               end
            end
            S_RUN: begin
               if (abort_wr) begin
                  state_q <= (out_valid_q && out_tbl_q && !bus.cmd_ready) ? S_ABORT : S_IDLE;
               end else if (last_hs) begin
                  state_q      <= S_DONE;
                  done_q       <= 1'b1;
                  sched_done_q <= 1'b1;
               end
            end
            S_ABORT: begin
               if (tbl_hs || !(out_valid_q && out_tbl_q)) state_q <= S_IDLE;
            end
            S_DONE: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
         for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
      end else if (wr_tbl) begin
         table_q[wr_off[TABLE_AW-1:0]] <= bus.up_wdata;
      end
   end

   // STATUS[17:16] exposes the FSM state for debug visibility.
   always_comb begin
      cfg_w                     = '0;
      cfg_w[TABLE_AW-1:0]       = last_idx_q;
      cfg_w[15:8]               = repeat_q;
      status_w                  = '0;
      status_w[0]               = busy;
      status_w[1]               = done_q;
      status_w[2]               = ovf_q;
      status_w[4 +: TABLE_AW]   = cur_idx_q;
      status_w[15:8]            = cur_rep_q;
      status_w[17:16]           = state_q;
      rd_mux                    = '0;
      case (rd_off)
         8'h01:   rd_mux = cfg_w;
         8'h02:   rd_mux = status_w;
         8'h04:   rd_mux = issued_q;
         default: if (rd_tbl) rd_mux = table_q[rd_off[TABLE_AW-1:0]];
      endcase
   end

   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
         wack_q     <= 1'b0;
         rack_q     <= 1'b0;
         rdata_q    <= '0;
         loop_q     <= 1'b0;
         last_idx_q <= '0;
         repeat_q   <= '0;
      end else begin
         wack_q  <= wr_win;
         rack_q  <= rd_win;
         rdata_q <= rd_win ? rd_mux : '0;
         if (wr_ctrl) loop_q <= bus.up_wdata[2];
         if (wr_cfg) begin
            last_idx_q <= bus.up_wdata[TABLE_AW-1:0];
            repeat_q   <= bus.up_wdata[15:8];
         end
      end
   end

   assign bus.up_wack    = wack_q;
   assign bus.up_rack    = rack_q;
   assign bus.up_rdata   = rdata_q;
   assign bus.cmd_valid  = out_valid_q;
   assign bus.cmd_data   = out_data_q;
   assign bus.sched_done = sched_done_q;
endmodule

// File: tb/tb_axi_ofdmbbp_rx_cmd_sched.sv
// Directed bench for axi_ofdmbbp_rx_cmd_sched: table sequencing, back-pressure, direct
// priority/overflow, abort, asynchronous reset and out-of-window accesses.
module tb_axi_ofdmbbp_rx_cmd_sched;
   localparam logic [13:0] BASE = 14'h0300;
   localparam logic [13:0] A_CTRL = BASE + 14'h00;
   localparam logic [13:0] A_CFG  = BASE + 14'h01;
   localparam logic [13:0] A_STAT = BASE + 14'h02;
   localparam logic [13:0] A_DIR  = BASE + 14'h03;
   localparam logic [13:0] A_ISS  = BASE + 14'h04;
   localparam logic [13:0] A_TBL  = BASE + 14'h80;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   axi_ofdmbbp_rx_cmd_sched_if bus ();

   axi_ofdmbbp_rx_cmd_sched #(.TABLE_AW(4), .BASE_ADDR(BASE)) dut (
      .up_clk  (clk),
      .up_rstn (rst_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt = 0;
   logic [31:0] exp_q[$];
   logic        stall_prev = 1'b0;
   logic [31:0] held_data  = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reg_wr(input logic [13:0] a, input logic [31:0] d);
      bus.up_wreq  = 1'b1;
      bus.up_waddr = a;
      bus.up_wdata = d;
      tick();
      bus.up_wreq  = 1'b0;
   endtask

   task automatic reg_rd(input logic [13:0] a, output logic [31:0] d, output logic ack);
      bus.up_rreq  = 1'b1;
      bus.up_raddr = a;
      tick();
      bus.up_rreq  = 1'b0;
      d   = bus.up_rdata;
      ack = bus.up_rack;
   endtask

   task automatic wait_done(input string tag, input int start_cnt);
      int n;
      n = 0;
      while (done_cnt == start_cnt && n < 100) begin
         tick();
         n++;
      end
      check(tag, (done_cnt == start_cnt) ? 32'd0 : 32'd1, 32'd1);
   endtask

   task automatic load_table();
      reg_wr(A_TBL + 14'd0, 32'h11);
      reg_wr(A_TBL + 14'd1, 32'h22);
      reg_wr(A_TBL + 14'd2, 32'h33);
   endtask

   // Scoreboard: every accepted command must be the next expected one; a stalled command must hold.
   always @(negedge clk) begin
      if (stall_prev && rst_n) begin
         check("hold_valid", {31'd0, bus.cmd_valid}, 32'd1);
         check("hold_data", bus.cmd_data, held_data);
      end
      if (bus.cmd_valid && bus.cmd_ready && rst_n) begin
         if (exp_q.size() == 0) check("unexpected_cmd", bus.cmd_data, 32'hDEAD_BEEF);
         else check("cmd_order", bus.cmd_data, exp_q.pop_front());
      end
      if (bus.sched_done) done_cnt++;
      stall_prev = bus.cmd_valid && !bus.cmd_ready && rst_n;
      held_data  = bus.cmd_data;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic        ack;
      int          dc;

      bus.up_wreq = 1'b0; bus.up_waddr = '0; bus.up_wdata = '0;
      bus.up_rreq = 1'b0; bus.up_raddr = '0; bus.cmd_ready = 1'b1;

      // reset values
      #3;
      check("rst_wack", {31'd0, bus.up_wack}, 32'd0);
      check("rst_rack", {31'd0, bus.up_rack}, 32'd0);
      check("rst_rdata", bus.up_rdata, 32'd0);
      check("rst_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
      check("rst_cmd_data", bus.cmd_data, 32'd0);
      check("rst_sched_done", {31'd0, bus.sched_done}, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      tick();

      // test 1: two passes over three entries, full throughput
      load_table();
      reg_wr(A_CFG, 32'h0000_0102);
      check("cfg_wack", {31'd0, bus.up_wack}, 32'd1);
      reg_rd(A_CFG, d, ack);
      check("cfg_rack", {31'd0, ack}, 32'd1);
      check("cfg_read", d, 32'h0000_0102);
      exp_q = '{32'h11, 32'h22, 32'h33, 32'h11, 32'h22, 32'h33};
      dc = done_cnt;
      reg_wr(A_CTRL, 32'h1);
      tick();
      for (int i = 0; i < 6; i++) begin
         check("t1_valid", {31'd0, bus.cmd_valid}, 32'd1);
         check("t1_data", bus.cmd_data, (i % 3 == 0) ? 32'h11 : (i % 3 == 1) ? 32'h22 : 32'h33);
         tick();
      end
      check("t1_sched_done", {31'd0, bus.sched_done}, 32'd1);
      check("t1_valid_off", {31'd0, bus.cmd_valid}, 32'd0);
      reg_rd(A_ISS, d, ack);
      check("t1_issued", d, 32'd6);
      reg_rd(A_STAT, d, ack);
      check("t1_status_done", d & 32'h7, 32'h2);
      reg_rd(A_STAT, d, ack);
      check("t1_status_clr", d & 32'h7, 32'h0);
      check("t1_done_pulses", done_cnt - dc, 32'd1);
      check("t1_sb_empty", exp_q.size(), 32'd0);

      // test 2: back-pressure for five cycles on the second command
      exp_q = '{32'h11, 32'h22, 32'h33, 32'h11, 32'h22, 32'h33};
      dc = done_cnt;
      reg_wr(A_CTRL, 32'h1);
      tick();
      check("t2_first", bus.cmd_data, 32'h11);
      tick();
      bus.cmd_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("t2_stall_data", bus.cmd_data, 32'h22);
         tick();
      end
      bus.cmd_ready = 1'b1;
      wait_done("t2_done_seen", dc);
      tick();
      reg_rd(A_ISS, d, ack);
      check("t2_issued", d, 32'd12);
      check("t2_sb_empty", exp_q.size(), 32'd0);
      reg_rd(A_STAT, d, ack);

      // test 3: direct command priority and overflow
      reg_wr(A_CFG, 32'h0000_0002);
      exp_q = '{32'h11, 32'h22, 32'h0000_ABCD, 32'h33};
      dc = done_cnt;
      reg_wr(A_CTRL, 32'h1);
      tick();
      check("t3_first", bus.cmd_data, 32'h11);
      reg_wr(A_DIR, 32'h0000_ABCD);
      check("t3_second", bus.cmd_data, 32'h22);
      reg_wr(A_DIR, 32'h0000_5555);
      check("t3_direct", bus.cmd_data, 32'h0000_ABCD);
      wait_done("t3_done_seen", dc);
      reg_rd(A_STAT, d, ack);
      check("t3_status_ovf", d & 32'h7, 32'h6);
      check("t3_sb_empty", exp_q.size(), 32'd0);

      // test 4: abort while a table command is held
      reg_wr(A_CFG, 32'h0);
      bus.cmd_ready = 1'b0;
      dc = done_cnt;
      reg_wr(A_CTRL, 32'h5);
      tick();
      check("t4_held", bus.cmd_data, 32'h11);
      exp_q = '{32'h11};
      reg_wr(A_CTRL, 32'h6);
      repeat (2) tick();
      check("t4_valid_kept", {31'd0, bus.cmd_valid}, 32'd1);
      reg_rd(A_STAT, d, ack);
      check("t4_busy", d & 32'h1, 32'h1);
      bus.cmd_ready = 1'b1;
      tick();
      check("t4_valid_off", {31'd0, bus.cmd_valid}, 32'd0);
      reg_rd(A_STAT, d, ack);
      check("t4_idle", d & 32'h3, 32'h0);
      check("t4_no_done", done_cnt - dc, 32'd0);
      check("t4_sb_empty", exp_q.size(), 32'd0);

      // test 5: asynchronous reset in RUN with a command held
      reg_wr(A_CFG, 32'h2);
      bus.cmd_ready = 1'b0;
      reg_wr(A_CTRL, 32'h1);
      tick();
      check("t5_valid_before", {31'd0, bus.cmd_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("t5_valid_async", {31'd0, bus.cmd_valid}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      bus.cmd_ready = 1'b1;
      tick();
      reg_rd(A_TBL + 14'd1, d, ack);
      check("t5_table_clr", d, 32'd0);
      reg_rd(A_STAT, d, ack);
      check("t5_status_clr", d, 32'd0);
      reg_rd(A_ISS, d, ack);
      check("t5_issued_clr", d, 32'd0);

      // test 6: accesses outside the register window
      reg_wr(14'h0285, 32'h1234_5678);
      check("t6_wack", {31'd0, bus.up_wack}, 32'd0);
      reg_rd(14'h0200, d, ack);
      check("t6_rack", {31'd0, ack}, 32'd0);
      check("t6_rdata", d, 32'd0);
      reg_rd(A_TBL + 14'd5, d, ack);
      check("t6_table_untouched", d, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
